// File: rtl/axis_uart_tx_if.sv
// AXI-Stream byte channel feeding the UART transmitter.
interface axis_uart_tx_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/axis_uart_tx.sv
// AXI-Stream to UART TX serializer: start bit, LSB-first data, optional even
// parity (compiled in with `define UART_TX_PARITY_EN), STOP_BITS stop bits.
module axis_uart_tx #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  axis_uart_tx_if.slave   s_axis,
  output logic            tx,
  output logic            busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] TIMER_MAX = 16'(CLK_DIV - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]  DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);

`ifdef UART_TX_PARITY_EN
  function automatic logic f_even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_timer;
  logic [15:0] w_timer_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_tx;
  logic        w_tx_nxt;
  logic        w_bit_end;
  logic        w_s_ready;
  logic        w_accept;
  logic [7:0]  w_load;
`ifdef UART_TX_PARITY_EN
  logic        r_par;
  logic        w_par_nxt;
`endif

  // Ready in IDLE and in the last cycle of the last stop bit, so frames can abut.
  assign w_bit_end      = (r_timer == TIMER_MAX);
  assign w_s_ready      = (r_state == ST_IDLE) ||
                          ((r_state == ST_STOP) && w_bit_end && (r_idx == STOP_LAST));
  assign w_accept       = s_axis.s_valid & w_s_ready;
  assign w_load         = s_axis.s_data & DATA_MASK;
  assign s_axis.s_ready = w_s_ready;
  assign tx             = r_tx;
  assign busy           = (r_state != ST_IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Next-state, bit timer, bit index and shift register.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = w_bit_end ? 16'd0 : (r_timer + 16'd1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = 16'd0;
        if (w_accept) begin
          w_state_nxt = ST_START;
          w_shift_nxt = w_load;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = f_even_parity(w_load);
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = 3'd0;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_idx == DATA_LAST) begin
            w_idx_nxt   = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_idx_nxt   = 3'd0;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_idx == STOP_LAST) begin
            w_idx_nxt = 3'd0;
            if (w_accept) begin
              w_state_nxt = ST_START;
              w_shift_nxt = w_load;
`ifdef UART_TX_PARITY_EN
              w_par_nxt   = f_even_parity(w_load);
`endif
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = 16'd0;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Line level for the coming cycle, registered so tx moves on the same edge as the state.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      ST_IDLE:   w_tx_nxt = 1'b1;
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = w_par_nxt;
`endif
      ST_STOP:   w_tx_nxt = 1'b1;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Scoreboard bench for axis_uart_tx: accepted bytes are queued, monitors decode
// each frame cycle-by-cycle against an ideal UART waveform built from the byte.
module tb_axis_uart_tx;

  localparam int A_DIV = 4;
  localparam int A_DB  = 8;
  localparam int A_SB  = 1;
  localparam int B_DIV = 3;
  localparam int B_DB  = 8;
  localparam int B_SB  = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_a, busy_a, tx_b, busy_b;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_uart_tx_if ifa ();
  axis_uart_tx_if ifb ();

  axis_uart_tx #(.CLK_DIV(A_DIV), .DATA_BITS(A_DB), .STOP_BITS(A_SB)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_axis(ifa), .tx(tx_a), .busy(busy_a));

  axis_uart_tx #(.CLK_DIV(B_DIV), .DATA_BITS(B_DB), .STOP_BITS(B_SB)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_axis(ifb), .tx(tx_b), .busy(busy_b));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic int div_of(input int w);
    return (w == 0) ? A_DIV : B_DIV;
  endfunction

  function automatic int nbits(input int w);
    return (w == 0) ? (1 + A_DB + PAR + A_SB) : (1 + B_DB + PAR + B_SB);
  endfunction

  // Ideal line level of frame bit b for byte d: start, data LSB first, parity, stops.
  function automatic logic exp_bit(input int w, input logic [7:0] d, input int b);
    int   db;
    logic p;
    db = (w == 0) ? A_DB : B_DB;
    p  = 1'b0;
    for (int i = 0; i < db; i++) p = p ^ d[i];
    if (b == 0) return 1'b0;
    if (b <= db) return d[b-1];
    if ((PAR == 1) && (b == db + 1)) return p;
    return 1'b1;
  endfunction

  task automatic drive(input int w, input logic v, input logic [7:0] d);
    if (w == 0) begin ifa.s_valid = v; ifa.s_data = d; end
    else begin ifb.s_valid = v; ifb.s_data = d; end
  endtask

  // Called right after a negedge; returns at the negedge following the accept edge.
  task automatic send(input int w, input logic [7:0] d, input bit wiggle, output int acc);
    logic [7:0] cur;
    acc = -1;
    cur = d;
    drive(w, 1'b1, cur);
    for (int k = 0; k < 400; k++) begin
      if (wiggle && (k > 0)) begin
        cur = 8'($urandom);
        drive(w, 1'b1, cur);
      end
      if (((w == 0) ? ifa.s_ready : ifb.s_ready) == 1'b1) begin
        if (w == 0) q_a.push_back(cur); else q_b.push_back(cur);
        acc = cyc;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout_%0d: byte %02h never accepted", w, d);
    end
  endtask

  task automatic wait_idle(input int w);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (((w == 0) ? busy_a : busy_b) == 1'b0 &&
          ((w == 0) ? q_a.size() : q_b.size()) == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("idle_timeout_%0d", w), {31'd0, done}, 32'd1);
  endtask

  task automatic monitor(input int w);
    logic       tx_w[0:63];
    logic       bz_w[0:63];
    logic [7:0] d;
    int         len, div, bad_at;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n && (((w == 0) ? tx_a : tx_b) == 1'b0)) begin
        div = div_of(w);
        len = div * nbits(w);
        aborted = 1'b0;
        for (int i = 0; i < len; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          tx_w[i] = (w == 0) ? tx_a : tx_b;
          bz_w[i] = (w == 0) ? busy_a : busy_b;
        end
        if (!aborted) begin
          n_vec++;
          if (((w == 0) ? q_a.size() : q_b.size()) == 0) begin
            n_err++;
            $display("FAIL frame_%0d: start bit seen, got a frame, expected no frame", w);
          end else begin
            d = (w == 0) ? q_a.pop_front() : q_b.pop_front();
            bad_at = -1;
            for (int i = 0; i < len; i++) begin
              if ((bad_at < 0) && ((tx_w[i] !== exp_bit(w, d, i / div)) || (bz_w[i] !== 1'b1)))
                bad_at = i;
            end
            if (bad_at >= 0) begin
              n_err++;
              $display("FAIL frame_%0d byte %02h cycle %0d: got tx=%b busy=%b, expected tx=%b busy=1",
                       w, d, bad_at, tx_w[bad_at], bz_w[bad_at], exp_bit(w, d, bad_at / div));
            end
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    int a1, a2, bad, gap;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx_a}, 32'd1);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_ready", {31'd0, ifa.s_ready}, 32'd1);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || ifa.s_ready !== 1'b1 || tx_b !== 1'b1) bad++;
    end
    check("idle_stable_bad_cycles", 32'(bad), 32'd0);

    // Single byte 0xA5: ready/busy window around the frame
    send(0, 8'hA5, 1'b0, a1);
    drive(0, 1'b0, 8'h00);
    bad = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0)  check("a5_ready_first", {31'd0, ifa.s_ready}, 32'd0);
      if (k == 39) check("a5_ready_last_stop", {31'd0, ifa.s_ready}, 32'd1);
      if (k == 39) check("a5_busy_last", {31'd0, busy_a}, 32'd1);
      if (k == 40) check("a5_busy_after", {31'd0, busy_a}, 32'd0);
      if ((k < 39) && (ifa.s_ready !== 1'b0 || busy_a !== 1'b1)) bad++;
    end
    check("a5_window_bad_cycles", 32'(bad), 32'd0);
    wait_idle(0);

    // Back-to-back 0x00, 0xFF
    send(0, 8'h00, 1'b0, a1);
    send(0, 8'hFF, 1'b0, a2);
    drive(0, 1'b0, 8'h00);
    check("b2b_accept_spacing", 32'(a2 - a1), 32'(A_DIV * nbits(0)));
    wait_idle(0);

    // Back-pressure with data changing while waiting
    send(0, 8'h3C, 1'b0, a1);
    send(0, 8'h81, 1'b1, a2);
    drive(0, 1'b0, 8'h00);
    check("bp_accept_spacing", 32'(a2 - a1), 32'(A_DIV * nbits(0)));
    wait_idle(0);

    // Two stop bits, CLK_DIV=3
    send(1, 8'h01, 1'b0, a1);
    drive(1, 1'b0, 8'h00);
    bad = 0;
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) @(negedge clk);
      if ((k >= 33 - 6 - 3 * PAR + 3 * PAR) && (k < 33) && (PAR == 0) && (tx_b !== 1'b1)) bad++;
      if ((k == 3 * nbits(1) - 1)) check("sb2_busy_last", {31'd0, busy_b}, 32'd1);
      if ((k == 33) && (PAR == 0)) check("sb2_busy_after", {31'd0, busy_b}, 32'd0);
    end
    check("sb2_final_stop_bad", 32'(bad), 32'd0);
    wait_idle(1);

`ifdef UART_TX_PARITY_EN
    // Parity bit value and 44-cycle frame
    send(0, 8'h07, 1'b0, a1);
    drive(0, 1'b0, 8'h00);
    for (int k = 0; k <= 44; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 37) check("par07_bit", {31'd0, tx_a}, 32'd1);
      if (k == 43) check("par07_busy_last", {31'd0, busy_a}, 32'd1);
      if (k == 44) check("par07_busy_after", {31'd0, busy_a}, 32'd0);
    end
    send(0, 8'h03, 1'b0, a1);
    drive(0, 1'b0, 8'h00);
    for (int k = 0; k <= 38; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 37) check("par03_bit", {31'd0, tx_a}, 32'd0);
    end
    wait_idle(0);
`endif

    // Reset during data bit 3 of 0x96 (bit 3 is 0, so tx must jump high)
    send(0, 8'h96, 1'b0, a1);
    drive(0, 1'b0, 8'h00);
    repeat (17) @(negedge clk);
    check("pre_rst_tx_low", {31'd0, tx_a}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tx", {31'd0, tx_a}, 32'd1);
    check("midrst_ready", {31'd0, ifa.s_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    q_a.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h5A, 1'b0, a1);
    drive(0, 1'b0, 8'h00);
    wait_idle(0);

    // Randomized bytes with random gaps on both instances
    for (int i = 0; i < 16; i++) begin
      send(0, 8'($urandom), 1'b0, a1);
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        drive(0, 1'b0, 8'h00);
        repeat (gap) @(negedge clk);
      end
    end
    drive(0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      send(1, 8'($urandom), 1'b0, a1);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        drive(1, 1'b0, 8'h00);
        repeat (gap) @(negedge clk);
      end
    end
    drive(1, 1'b0, 8'h00);
    wait_idle(0);
    wait_idle(1);
    repeat (5) @(negedge clk);
    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_b_drained", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
